// File: rtl/int_pkg.sv
// int_pkg: shared state/source encodings and default vector indices for the interrupt sequencer.
package int_pkg;
  typedef enum logic [1:0] {IDLE, REQ, VEC, SERVICE} int_state_e;
  typedef enum logic {INT_SRC_HW = 1'b0, INT_SRC_SW = 1'b1} int_src_e;
  localparam int HWINT_VEC_IDX = 1;
  localparam int SWINT_VEC_IDX = 2;
endpackage

// File: rtl/int_pending_latch.sv
// int_pending_latch: set-priority pending flop; EDGE=1 sets on a 0->1 of d, else on d high.
module int_pending_latch #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic clr,
  output logic pend,
  output logic hit
);
  if (EDGE) begin : g_edge
    logic prev;
    always_ff @(posedge clk or posedge rst)
      if (rst) prev <= 1'b0;
      else prev <= d;
    assign hit = d & ~prev;
  end else begin : g_level
    assign hit = d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pend <= 1'b0;
    else pend <= hit | (pend & ~clr);
endmodule

// File: rtl/int_vector_seq.sv
// int_vector_seq: arbitrates HW/SW interrupts, raises irq, drives the vector select on ack.
// Define INT_VECTOR_SEQ_HWINT_EDGE_EN for an edge-triggered, latched hwint.
module int_vector_seq
  import int_pkg::*;
#(
  parameter int SEL_WIDTH = 4,
  parameter int HWINT_SEL = HWINT_VEC_IDX,
  parameter int SWINT_SEL = SWINT_VEC_IDX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hwint,
  input  logic                 swint,
  input  logic                 ie,
  input  logic                 int_ack,
  input  logic                 reti,
  output logic                 irq,
  output logic                 vec_oe,
  output logic [SEL_WIDTH-1:0] vec_sel,
  output logic                 in_service,
  output logic                 int_src
);
  localparam logic [SEL_WIDTH-1:0] HW_SEL = SEL_WIDTH'(HWINT_SEL);
  localparam logic [SEL_WIDTH-1:0] SW_SEL = SEL_WIDTH'(SWINT_SEL);
  int_state_e state;
  int_src_e   src;
  logic sw_pend, sw_hit, sw_valid, hw_req;
  // The same-cycle swint counts so a request reaches irq one cycle later.
  assign sw_valid = sw_pend | sw_hit;
  int_pending_latch #(.EDGE(1'b0)) u_sw_pend (
    .clk(clk), .rst(rst), .d(swint),
    .clr(state == VEC && src == INT_SRC_SW),
    .pend(sw_pend), .hit(sw_hit)
  );
`ifdef INT_VECTOR_SEQ_HWINT_EDGE_EN
  logic hw_pend, hw_hit;
  int_pending_latch #(.EDGE(1'b1)) u_hw_pend (
    .clk(clk), .rst(rst), .d(hwint),
    .clr(state == VEC && src == INT_SRC_HW),
    .pend(hw_pend), .hit(hw_hit)
  );
  assign hw_req = (hw_pend | hw_hit) & ie;
`else
  assign hw_req = hwint & ie;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      src        <= INT_SRC_HW;
      irq        <= 1'b0;
      vec_oe     <= 1'b0;
      vec_sel    <= '0;
      in_service <= 1'b0;
      int_src    <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (hw_req || sw_valid) begin
            state <= REQ;
            src   <= hw_req ? INT_SRC_HW : INT_SRC_SW;
            irq   <= 1'b1;
          end
        REQ:
          if (int_ack) begin
            state   <= VEC;
            irq     <= 1'b0;
            vec_oe  <= 1'b1;
            vec_sel <= src == INT_SRC_HW ? HW_SEL : SW_SEL;
            int_src <= src == INT_SRC_SW;
          end else if (src == INT_SRC_HW && !hw_req) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        VEC: begin
          state      <= SERVICE;
          vec_oe     <= 1'b0;
          vec_sel    <= '0;
          in_service <= 1'b1;
        end
        SERVICE:
          if (reti) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
      endcase
    end
endmodule

// File: doc/int_vector_seq.md
Name: int_vector_seq

Overview:
- Interrupt sequencer between the interrupt sources and the CPU control unit.
- Arbitrates the hardware interrupt line and software INT requests, and raises irq to the control unit.
- On acknowledge, drives oe/sel of the constants unit's A port for one cycle, so the vector index (HWINT=1, SWINT=2) appears on the A bus.
- Tracks in-service state until the control unit signals return-from-interrupt.

Parameters:
- SEL_WIDTH, 4, width of the constants-unit select.
- HWINT_SEL, 1, constants-unit index holding the HWINT vector.
- SWINT_SEL, 2, constants-unit index holding the SWINT vector.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- hwint  input  1  hardware interrupt request (level).
- swint  input  1  single-cycle pulse from control unit executing INT.
- ie  input  1  hardware interrupt enable. Software interrupts are never masked.
- int_ack  input  1  control unit accepts interrupt at an instruction boundary.
- reti  input  1  single-cycle pulse, return from interrupt.
- irq  output  1  interrupt pending, to control unit.
- vec_oe  output  1  to constants unit oe_a.
- vec_sel  output  SEL_WIDTH  to constants unit sel_a.
- in_service  output  1  handler running.
- int_src  output  1  source of current/last dispatched interrupt: 0 = HW, 1 = SW.

Behaviour:
- Reset (async, immediate):
  - State IDLE; sw_pend=0.
  - irq, vec_oe, in_service, int_src = 0; vec_sel = 0.
  - Reset asserted during VEC drops vec_oe in the same cycle.
- sw_pend:
  - Set on any cycle with swint=1.
  - Cleared on the VEC cycle of a SW dispatch.
  - Set wins over clear when both occur in the same cycle.
- hw_req (level mode) = hwint & ie, sampled each cycle.
- Arbitration: HW has priority over SW when both are valid in the same IDLE cycle.
- FSM, all outputs registered:
  - IDLE:
    - if hw_req → REQ, src=HW.
    - else if sw_pend → REQ, src=SW.
    - else stay.
  - REQ:
    - irq=1; src locked.
    - int_ack=1 → VEC.
    - If src=HW and hw_req falls before ack → IDLE (retraction). irq drops next cycle; pending SW is re-arbitrated from IDLE.
    - Ack and retraction in the same cycle: ack wins.
  - VEC:
    - Exactly one cycle. vec_oe=1, vec_sel = HWINT_SEL or SWINT_SEL per src; int_src updated.
    - irq=0. → SERVICE.
  - SERVICE:
    - in_service=1; stays until reti=1, then → IDLE.
    - New swint/hwint are held (sw_pend latched, hwint level) and not dispatched.
- Minimum latency: request to irq = 1 cycle; int_ack to vec_oe = 1 cycle; reti to next irq = 2 cycles (SERVICE→IDLE→REQ).
- Outside VEC: vec_oe=0, vec_sel=0.
- Ignored inputs: int_ack outside REQ, reti outside SERVICE.
- Single-bit state only; no wrap-around concerns.

Optional Feature:
- Macro: INT_VECTOR_SEQ_HWINT_EDGE_EN.
- Defined:
  - hwint is edge-triggered. A registered prev-sample detects 0→1, which sets hw_pend.
  - hw_pend is cleared on the VEC cycle of a HW dispatch; a set on that same cycle wins.
  - hw_req = hw_pend & ie.
  - A rising edge while ie=0 is kept pending.
  - Retraction in REQ happens only on ie falling; hw_pend is retained.
- Undefined: level mode as in Behaviour; no hw_pend register exists.

Decomposition:
- Shared package (int_pkg):
  - state enum int_state_e {IDLE, REQ, VEC, SERVICE}.
  - int_src_e {INT_SRC_HW=0, INT_SRC_SW=1}.
  - Localparams HWINT_VEC_IDX=1, SWINT_VEC_IDX=2, used as parameter defaults.
- Sub-module int_pending_latch (set-priority set/clear flop with optional edge detect): instantiated for sw_pend, and for hw_pend under the macro.

Test Plan:
- HW dispatch:
  - Stimulus: hwint=1, ie=1 at cycle 0; int_ack at cycle 3; reti at cycle 8.
  - Response: irq=1 in cycles 1–3; vec_oe=1, vec_sel=1 in cycle 4; int_src=0; in_service=1 in cycles 5–8; IDLE at 9.
- SW unmasked:
  - Stimulus: ie=0, swint pulse at cycle 0, int_ack at cycle 2.
  - Response: irq at cycle 1; vec_sel=2 with vec_oe=1 at cycle 3; int_src=1; sw_pend cleared.
- Priority:
  - Stimulus: swint pulse and hwint=1, ie=1 in the same cycle.
  - Response: first dispatch vec_sel=1. After reti, SW dispatch vec_sel=2 with no new swint.
- Retraction:
  - Stimulus: hwint=1, ie=1; irq rises; hwint=0 before int_ack.
  - Response: irq=0 next cycle, no vec_oe. Ack arriving the cycle after retraction is ignored.
- Held during SERVICE:
  - Stimulus: swint pulse while in_service=1.
  - Response: no irq until reti; irq 2 cycles after reti; vec_sel=2 on ack.
- Async reset:
  - Stimulus: assert rst mid-VEC (between clock edges).
  - Response: vec_oe/irq/in_service=0 immediately; after release, no dispatch unless a new request arrives.
- Edge mode (macro on):
  - Stimulus: hwint held 1 through dispatch and reti.
  - Response: exactly one dispatch. A 0→1 edge with ie=0 dispatches once ie=1.
